// File: rtl/d_wb_pkg.sv
// Shared types for the posted-write buffer: FSM state and the buffered write entry.
package d_wb_pkg;

   localparam int WB_A_WIDTH = 32;

   typedef enum logic [1:0] {IDLE, DRAIN, READ} wb_state_t;

   typedef struct packed {
      logic [WB_A_WIDTH-1:0] addr;
      logic [31:0]           data;
      logic [3:0]            wen;
      logic [1:0]            size;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with async active-low reset; dout always shows the head entry.
module wb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // Storage needs no reset: the head is only observed while count != 0.
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= din;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/d_write_buffer.sv
// Posted-write buffer between the L3 data cache and memory: writes are absorbed and drained
// in order; reads go out only once every buffered write has reached memory.
module d_write_buffer
   import d_wb_pkg::*;
#(
   parameter int A_WIDTH = WB_A_WIDTH,
   parameter int DEPTH   = 4,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] c_a,
   input  logic [31:0]        c_din,
   output logic [31:0]        c_dout,
   input  logic               c_strobe,
   input  logic [3:0]         c_wen,
   input  logic [1:0]         c_size,
   input  logic               c_rw,
   output logic               c_ready,
   output logic [A_WIDTH-1:0] m_a,
   output logic [31:0]        m_din,
   input  logic [31:0]        m_dout,
   output logic               m_strobe,
   output logic [3:0]         m_wen,
   output logic [1:0]         m_size,
   output logic               m_rw,
   input  logic               m_ready,
   output logic               wb_empty
);

   wb_state_t          state;
   logic [A_WIDTH-1:0] rd_a;
   logic [1:0]         rd_size;
   wb_entry_t          enq, head;
   logic               full, empty, push, pop;
   logic [PTR_W:0]     count;

   // Entry address field is sized by the package; A_WIDTH above that needs a package change.
   assign enq = '{addr: WB_A_WIDTH'(c_a), data: c_din, wen: c_wen, size: c_size};

   // Accept depends only on occupancy, never on m_ready; held off during reset and READ.
   assign push = clrn & c_strobe & c_rw & ~full & (state != READ);
   assign pop  = (state == DRAIN) & m_ready;

   wb_fifo #(.W($bits(wb_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .clrn  (clrn),
      .push  (push),
      .pop   (pop),
      .din   (enq),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign wb_empty = empty;

   // A write accepted in IDLE goes straight to DRAIN so memory sees it the next cycle.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state   <= IDLE;
         rd_a    <= '0;
         rd_size <= '0;
      end else begin
         case (state)
            IDLE:
               if (count != '0 || push) state <= DRAIN;
               else if (c_strobe && !c_rw) begin
                  state   <= READ;
                  rd_a    <= c_a;
                  rd_size <= c_size;
               end
            DRAIN:
               if (pop && count == (PTR_W+1)'(1) && !push) state <= IDLE;
            READ:
               if (m_ready) state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_strobe = 1'b0;
      m_rw     = 1'b0;
      m_a      = '0;
      m_din    = '0;
      m_wen    = '0;
      m_size   = '0;
      c_dout   = '0;
      case (state)
         DRAIN: begin
            m_strobe = 1'b1;
            m_rw     = 1'b1;
            m_a      = A_WIDTH'(head.addr);
            m_din    = head.data;
            m_wen    = head.wen;
            m_size   = head.size;
         end
         READ: begin
            m_strobe = 1'b1;
            m_a      = rd_a;
            m_size   = rd_size;
            c_dout   = m_dout;
         end
         default: ;
      endcase
   end

   assign c_ready = push | ((state == READ) & c_strobe & ~c_rw & m_ready);

endmodule
